// File: rtl/d_mem_responder.sv
// ---------------------------------------------------------------------------
// d_mem_responder
//
// Memory-side responder for CPU data accesses. It accepts one load or store per
// valid/ready handshake. It then inserts WAIT_CYCLES wait states and returns a
// one-cycle response. Storage is a word-addressed register array.
//
// The store write, the load read and the response registers all update on one
// edge: the edge that enters RESP (the commit edge). A load therefore sees
// every store that committed before it.
//
// Ports
//   clock       in   1   single clock, rising edge
//   reset       in   1   synchronous, active-high
//   req_valid   in   1   CPU presents a request
//   req_ready   out  1   responder can accept (high only in IDLE)
//   req_write   in   1   1 = store, 0 = load
//   req_addr    in   32  byte address, must be word aligned
//   req_wdata   in   32  store data
//   resp_valid  out  1   one-cycle pulse per accepted request
//   resp_rdata  out  32  load data; 0 for stores and errors
//   resp_error  out  1   misaligned or out-of-range address
// ---------------------------------------------------------------------------
module d_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_error_q, resp_error_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic             accept;
    logic             commit;
    logic             op_write;
    logic [31:0]      op_addr;
    logic [31:0]      op_wdata;
    logic             addr_err;
    logic [IDX_W-1:0] mem_idx;
    logic             mem_we;

    // -----------------------------------------------------------------------
    // State register (plus latched request and response registers)
    // -----------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so that every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            wr_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
        end
    end

    // NOTE: the data array has no reset branch. Contents survive reset, and
    // leaving storage unreset lets it map onto plain storage cells.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[mem_idx] <= op_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every signal gets a default at the top of each combinational
    // block, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output / datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        req_ready = (state_q == S_IDLE);
        accept    = req_valid && req_ready;
        commit    = (state_d == S_RESP) && (state_q != S_RESP);

        // With zero wait states the commit edge is also the accept edge. At
        // that edge the request has not been latched yet, so the live inputs
        // are used instead.
        op_write  = (state_q == S_IDLE) ? req_write : wr_q;
        op_addr   = (state_q == S_IDLE) ? req_addr  : addr_q;
        op_wdata  = (state_q == S_IDLE) ? req_wdata : wdata_q;

        addr_err  = (op_addr[1:0] != 2'b00) ||
                    ({2'b00, op_addr[31:2]} >= 32'(DEPTH_WORDS));
        mem_idx   = op_addr[IDX_W+1:2];

        // A reset on the commit edge discards the store.
        mem_we    = commit && op_write && !addr_err && !reset;

        wr_d      = accept ? req_write : wr_q;
        addr_d    = accept ? req_addr  : addr_q;
        wdata_d   = accept ? req_wdata : wdata_q;

        // A load reads the array before any write lands on the same edge.
        resp_valid_d = commit;
        resp_error_d = commit && addr_err;
        resp_rdata_d = (commit && !op_write && !addr_err) ? mem_q[mem_idx] : 32'd0;
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_error = resp_error_q;

endmodule

// File: tb/tb_d_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_d_mem_responder
//
// Two instances are driven from one clock:
//   dut  : WAIT_CYCLES=2. It gets directed and random single transactions.
//   dut0 : WAIT_CYCLES=0. req_valid stays high and a queue scoreboard tracks
//          the responses.
// Expected values come from an array model of the memory and the rules for
// address errors.
// ---------------------------------------------------------------------------
module tb_d_mem_responder;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // WAIT_CYCLES = 2 instance
    logic        reset, req_valid, req_write, req_ready, resp_valid, resp_error;
    logic [31:0] req_addr, req_wdata, resp_rdata;

    // WAIT_CYCLES = 0 instance
    logic        reset0, req_valid0, req_write0, req_ready0, resp_valid0, resp_error0;
    logic [31:0] req_addr0, req_wdata0, resp_rdata0;

    d_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error)
    );

    d_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .clock      (clock),
        .reset      (reset0),
        .req_valid  (req_valid0),
        .req_ready  (req_ready0),
        .req_write  (req_write0),
        .req_addr   (req_addr0),
        .req_wdata  (req_wdata0),
        .resp_valid (resp_valid0),
        .resp_rdata (resp_rdata0),
        .resp_error (resp_error0)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] ref_mem  [256];
    logic [31:0] ref0_mem [256];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;
    resp_t q0 [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:2] >= 30'd256);
    endfunction

    // One complete transaction on dut. It checks the handshake, the latency,
    // the response contents and the one-cycle response pulse.
    task automatic txn(input bit wr, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          lat;
        exp_err   = addr_bad(a);
        exp_rdata = (!wr && !exp_err) ? ref_mem[a[9:2]] : 32'd0;
        @(negedge clock);
        check("ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            if (resp_valid === 1'b1) begin
                lat = i;
                break;
            end
            if (i == 1) check("ready_busy", req_ready, 0);
            @(negedge clock);
        end
        check("latency", lat, 3);
        check("rdata", resp_rdata, exp_rdata);
        check("error", resp_error, exp_err);
        @(negedge clock);
        check("resp_one_cycle", resp_valid, 0);
        if (wr && !exp_err) ref_mem[a[9:2]] = d;
    endtask

    // Next request for dut0. The first 16 requests store to words 0..15, so
    // every later load reads a word whose contents the model knows.
    task automatic gen0(input int n);
        int r;
        if (n < 16) begin
            req_write0 = 1'b1;
            req_addr0  = 32'(n * 4);
            req_wdata0 = $urandom;
        end else begin
            r          = $urandom_range(0, 9);
            req_write0 = 1'($urandom_range(0, 1));
            req_wdata0 = $urandom;
            if (r == 0)      req_addr0 = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else if (r == 1) req_addr0 = 32'h400 + 32'($urandom_range(0, 15) * 4);
            else             req_addr0 = 32'($urandom_range(0, 15) * 4);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [31:0] a;
        bit          prev_ready0;
        int          n0;
        resp_t       e;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        reset0     = 1'b1;
        req_valid0 = 1'b0;
        req_write0 = 1'b0;
        req_addr0  = 32'd0;
        req_wdata0 = 32'd0;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_resp_error", resp_error, 0);
        reset = 1'b0;

        // Give every word known contents
        for (int i = 0; i < 256; i++) txn(1'b1, 32'(i * 4), $urandom);

        // Store then load the same word
        txn(1'b1, 32'h10, 32'hDEADBEEF);
        txn(1'b0, 32'h10, 32'h0);

        // Misaligned and out-of-range loads, then confirm word 4 is unchanged
        txn(1'b0, 32'h13, 32'h0);
        txn(1'b0, 32'h400, 32'h0);
        txn(1'b1, 32'h13, 32'h55555555);
        txn(1'b1, 32'h400, 32'h66666666);
        txn(1'b0, 32'h10, 32'h0);

        // Back-to-back stores to one word
        txn(1'b1, 32'h0, 32'h1);
        txn(1'b1, 32'h0, 32'h2);
        txn(1'b0, 32'h0, 32'h0);
        check("b2b_model_word0", ref_mem[0], 32'h2);

        // Reset during WAIT discards the uncommitted store
        @(negedge clock);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h12345678;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        check("wait_ready_low", req_ready, 0);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("rst_wait_ready", req_ready, 1);
        check("rst_wait_resp_valid", resp_valid, 0);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("rst_wait_no_resp", resp_valid, 0);
        end
        txn(1'b0, 32'h20, 32'h0);

        // Reset during RESP: the committed store persists, outputs clear
        v = $urandom;
        @(negedge clock);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h24;
        req_wdata = v;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        repeat (2) @(negedge clock);
        check("resp_phase_valid", resp_valid, 1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("rst_resp_valid_clr", resp_valid, 0);
        check("rst_resp_rdata_clr", resp_rdata, 0);
        check("rst_resp_ready", req_ready, 1);
        reset = 1'b0;
        ref_mem[9] = v;
        txn(1'b0, 32'h24, 32'h0);

        // Random mix
        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0)      a = 32'($urandom_range(0, 255) * 4 + $urandom_range(1, 3));
            else if (r == 1) a = 32'h400 + 32'($urandom_range(0, 1023) * 4);
            else             a = 32'($urandom_range(0, 255) * 4);
            txn(1'($urandom_range(0, 1)), a, $urandom);
        end

        // Zero-wait instance with req_valid held high
        n0 = 0;
        gen0(n0);
        n0++;
        req_valid0 = 1'b1;
        @(negedge clock);
        reset0 = 1'b0;
        prev_ready0 = 1'b0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (resp_valid0 === 1'b1) begin
                if (q0.size() == 0) begin
                    check("w0_spurious_resp", 1, 0);
                end else begin
                    e = q0.pop_front();
                    check("w0_rdata", resp_rdata0, e.rdata);
                    check("w0_error", resp_error0, e.err);
                end
            end
            check("w0_ready_vs_resp", req_ready0, !resp_valid0);
            if (cyc > 0) check("w0_ready_alternates", req_ready0, !prev_ready0);
            prev_ready0 = req_ready0;
            if (req_ready0) begin
                e.err   = addr_bad(req_addr0);
                e.rdata = (!req_write0 && !e.err) ? ref0_mem[req_addr0[9:2]] : 32'd0;
                q0.push_back(e);
                if (req_write0 && !e.err) ref0_mem[req_addr0[9:2]] = req_wdata0;
            end else begin
                gen0(n0);
                n0++;
            end
            @(negedge clock);
        end
        req_valid0 = 1'b0;
        repeat (4) begin
            if (resp_valid0 === 1'b1) begin
                if (q0.size() == 0) begin
                    check("w0_spurious_resp", 1, 0);
                end else begin
                    e = q0.pop_front();
                    check("w0_rdata", resp_rdata0, e.rdata);
                    check("w0_error", resp_error0, e.err);
                end
            end
            @(negedge clock);
        end
        check("w0_all_responded", q0.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
